// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor: operands and start in, status and
// {borrow, difference} out.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   diff;

  modport master (output start, x, y, input busy, done, diff);
  modport slave  (input start, x, y, output busy, done, diff);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial x - y, LSB first through one borrow flip-flop; result word is
// {borrow_out, (x - y) mod 2^WIDTH}, written only when the last bit completes.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic         CLK,
  input  logic         reset_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, r;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   diff_q;
  logic             d, bout, last;

  assign d    = a[0] ^ b[0] ^ borrow;
  assign bout = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & borrow);
  assign last = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status decodes the state register only, so outputs stay registered.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      a      <= '0;
      b      <= '0;
      r      <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a      <= bus.x;
            b      <= bus.y;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a      <= {1'b0, a[WIDTH-1:1]};
          b      <= {1'b0, b[WIDTH-1:1]};
          r      <= {d, r[WIDTH-1:1]};
          borrow <= bout;
          cnt    <= cnt + CW'(1);
          // Final bit: publish the full word in one step so diff never shows partials.
          if (last) diff_q <= {bout, d, r[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.diff = diff_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic/timeline model checked every
// cycle, plus directed cases with hand-computed results.
module tb_serial_subtractor;

  localparam int W = 4;

  logic CLK = 1'b0;
  logic reset_n;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation accepted while idle finishes W edges later,
  // its result is plain (W+1)-bit x - y, and it occupies W+1 cycles.
  int           age      = -1;   // cycles since accept, -1 when idle
  logic [W:0]   pend     = '0;
  int           pend_s   = 0;
  logic [W:0]   exp_diff = '0;
  int           exp_s    = 0;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      age      = -1;
      exp_diff = '0;
    end else if (age < 0) begin
      if (bus.start) begin
        age    = 0;
        pend   = {1'b0, bus.x} - {1'b0, bus.y};
        pend_s = int'(bus.x) - int'(bus.y);
      end
    end else begin
      age++;
      if (age == W) begin
        exp_diff = pend;
        exp_s    = pend_s;
      end
      if (age == W + 1) age = -1;
    end
  end

  always @(negedge CLK) begin
    check("busy", bus.busy, (age >= 0));
    check("done", bus.done, (age == W));
    check("diff", bus.diff, exp_diff);
    if (bus.done) check("signed_diff", int'($signed(bus.diff)), exp_s);
  end

  // One operation from idle; optional second start pulse injected mid-SHIFT.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                        input logic [W:0] exp, input bit inject);
    int         n_busy = 0;
    int         n_done = 0;
    logic [W:0] got    = '0;
    bit         ended  = 0;
    bus.start = 1'b1;
    bus.x     = xa;
    bus.y     = ya;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.x     = W'($urandom);
        bus.y     = W'($urandom);
      end
      if (inject && k == 2) begin
        bus.start = 1'b1;
        bus.x     = W'(1);
        bus.y     = W'(1);
      end
      if (inject && k == 3) bus.start = 1'b0;
      if (bus.done) begin
        n_done++;
        got = bus.diff;
      end
      if (bus.busy) n_busy++;
      else begin
        ended = 1;
        break;
      end
    end
    check("op_finished", ended, 1);
    check("busy_cycles", n_busy, W + 1);
    check("done_pulses", n_done, 1);
    check("op_result", got, exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
    repeat (4) begin
      @(negedge CLK);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      bus.x = W'($urandom);
      bus.y = W'($urandom);
    end
    bus.start = 1'b0;
    reset_n   = 1'b1;
    @(negedge CLK);

    run_op(4'b1010, 4'b0111, 5'b00011, 0);
    run_op(4'b0111, 4'b1010, 5'b11101, 0);
    check("signed_m3", int'($signed(bus.diff)), -3);
    run_op(4'b1111, 4'b1111, 5'b00000, 0);
    run_op(4'b0000, 4'b0001, 5'b11111, 0);
    run_op(4'b1000, 4'b0000, 5'b01000, 0);
    run_op(4'b0110, 4'b0011, 5'b00011, 1);

    // Reset at the second SHIFT edge discards the operation immediately.
    bus.start = 1'b1;
    bus.x     = 4'b0101;
    bus.y     = 4'b0010;
    @(negedge CLK);
    bus.start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1 reset_n = 1'b0;
    #1;
    check("async_busy", bus.busy, 0);
    check("async_done", bus.done, 0);
    check("async_diff", bus.diff, 0);
    repeat (3) begin
      @(negedge CLK);
      check("no_done_in_rst", bus.done, 0);
    end
    reset_n = 1'b1;
    @(negedge CLK);
    run_op(4'b0101, 4'b0010, 5'b00011, 0);

    // Random traffic, including long stretches of start held high.
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.x     = W'($urandom);
      bus.y     = W'($urandom);
    end
    bus.start = 1'b0;
    repeat (8) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
